serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_ripple_subtractor.sv | 111 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell, with a start/busy/done handshake.
module serial_ripple_subtractor #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  sreg_a_q, sreg_a_d;
    logic [W-1:0]  sreg_b_q, sreg_b_d;
    logic          borrow_q, borrow_d;
    logic [W-1:0]  res_q,    res_d;
    logic [W-1:0]  diff_q,   diff_d;
    logic          bout_q,   bout_d;

    logic x, y, d_bit, br_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        x       = sreg_a_q[0];
        y       = sreg_b_q[0];
        d_bit   = x ^ y ^ borrow_q;
        br_next = (~x & y) | (~(x ^ y) & borrow_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_a_d = a;
                    sreg_b_d = b;
                    borrow_d = bin;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_d    = {d_bit, res_q[W-1:1]};
                sreg_a_d = {1'b0, sreg_a_q[W-1:1]};
                sreg_b_d = {1'b0, sreg_b_q[W-1:1]};
                borrow_d = br_next;
                cnt_d    = cnt_q + CW'(1);
                // MSB edge: publish the whole result at once so diff never shows partials
                if (cnt_q == CW'(W - 1)) begin
                    diff_d  = {d_bit, res_q[W-1:1]};
                    bout_d  = br_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed vectors, handshake
// timing, reset/abort cases and randomized operands against an arithmetic model.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_ripple_subtractor #(.W(W), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Reference: {bout, diff} is the (W+1)-bit two's-complement difference.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output logic [W-1:0] odiff, output logic obout, output int lat);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = -1;
        odiff = 'x; obout = 1'bx;
        for (int i = 1; i <= 3 * W; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i; odiff = diff; obout = bout;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, diff, bout} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b diff=%b bout=%b, required all 0",
                     busy, done, diff, bout);
        end
    endtask

    task automatic test_basic;
        int first_done = -1;
        a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy_at_accept: busy=%b required 1", busy);
        end
        for (int i = 1; i <= W + 1; i++) begin
            tick();
            if (done === 1'b1 && first_done < 0) first_done = i;
            if (i == W) begin
                n_checks++;
                if (diff !== 4'b0010 || bout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_result: diff=%b bout=%b required 0010/0", diff, bout);
                end
            end
        end
        n_checks++;
        if (first_done != W) begin
            n_fail++; $display("FAIL basic_latency: first done after %0d edges, required %0d", first_done, W);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_return_idle: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_vectors;
        logic [W-1:0] va[5]  = '{4'b0011, 4'b0000, 4'b1111, 4'b1111, 4'b1010};
        logic [W-1:0] vb[5]  = '{4'b0101, 4'b0000, 4'b1111, 4'b0000, 4'b1010};
        logic         vbi[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] vd[5]  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic         vbo[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] gd;
        logic         gb;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vbi[i], gd, gb, lat);
            n_checks++;
            if (lat != W || gd !== vd[i] || gb !== vbo[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: lat=%0d diff=%b bout=%b, required lat=%0d diff=%b bout=%b",
                         i, lat, gd, gb, W, vd[i], vbo[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start;
        int           n_done = 0;
        logic [W-1:0] gd = 'x;
        logic         gb = 1'bx;
        a = 4'b0110; b = 4'b0001; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'b0000; b = 4'b1111; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) begin
                n_done++; gd = diff; gb = bout;
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++; $display("FAIL ignore_start_pulses: %0d done pulses, required 1", n_done);
        end
        n_checks++;
        if (gd !== 4'b0101 || gb !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start_result: diff=%b bout=%b required 0101/0", gd, gb);
        end
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] gd;
        logic         gb;
        int           lat;
        int           n_done = 0;
        do_op(4'b1000, 4'b0001, 1'b0, gd, gb, lat);
        n_checks++;
        if (lat != W || gd !== 4'b0111 || gb !== 1'b0) begin
            n_fail++; $display("FAIL abort_pre_op: lat=%0d diff=%b bout=%b required %0d/0111/0", lat, gd, gb, W);
        end
        tick();
        a = 4'b0100; b = 4'b0010; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cleared: busy=%b done=%b diff=%b bout=%b required 0/0/0000/0",
                     busy, done, diff, bout);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++; $display("FAIL abort_no_done: %0d done pulses, required 0", n_done);
        end
        do_op(4'b0100, 4'b0010, 1'b0, gd, gb, lat);
        n_checks++;
        if (lat != W || gd !== 4'b0010 || gb !== 1'b0) begin
            n_fail++; $display("FAIL abort_fresh_op: lat=%0d diff=%b bout=%b required %0d/0010/0", lat, gd, gb, W);
        end
        tick();
    endtask

    task automatic test_reset_with_start;
        int lat = -1;
        reset = 1'b1; start = 1'b1; a = 4'b1001; b = 4'b0011; bin = 1'b0;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_beats_start: busy=%b required 0", busy);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL start_after_reset: busy=%b required 1", busy);
        end
        for (int i = 1; i <= 3 * W; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat != W || diff !== 4'b0110 || bout !== 1'b0) begin
            n_fail++; $display("FAIL start_after_reset_result: lat=%0d diff=%b bout=%b required %0d/0110/0", lat, diff, bout, W);
        end
        tick();
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, gd;
        logic         rbi, gb;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
            exp = model(ra, rb, rbi);
            do_op(ra, rb, rbi, gd, gb, lat);
            n_checks++;
            if (lat != W || {gb, gd} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d a=%b b=%b bin=%b: lat=%0d bout,diff=%b required lat=%0d %b",
                         i, ra, rb, rbi, lat, {gb, gd}, W, exp);
            end
            if ($urandom_range(0, 1) == 1) tick();
            else begin tick(); tick(); end
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] expq[$];
        logic [W:0] exp;
        logic       want_done;
        for (int cyc = 0; cyc < 24; cyc++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'b1;
            if (cyc % (W + 2) == 0) expq.push_back(model(a, b, bin));
            tick();
            want_done = ((cyc % (W + 2)) == W);
            n_checks++;
            if (done !== want_done) begin
                n_fail++; $display("FAIL b2b_done_cycle_%0d: done=%b required %b", cyc, done, want_done);
            end
            if (want_done && expq.size() > 0) begin
                exp = expq.pop_front();
                n_checks++;
                if ({bout, diff} !== exp) begin
                    n_fail++; $display("FAIL b2b_result_cycle_%0d: bout,diff=%b required %b", cyc, {bout, diff}, exp);
                end
            end
        end
        start = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_reset_with_start();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
